// File: rtl/parity_frame_serializer_pkg.sv
// Shared state encoding for the serial-stream blocks.
package parity_frame_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/parity_frame_serializer.sv
// Parallel-to-serial framer: sends DATA_W bits MSB first followed by one
// even-parity bit, so each DATA_W+1 bit frame carries an even number of ones.
module parity_frame_serializer
  import parity_frame_serializer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_end,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_parity;
  logic                w_parity_nxt;
  logic                r_dout;
  logic                w_dout_nxt;
  logic                r_dout_valid;
  logic                w_dout_valid_nxt;
  logic                r_frame_end;
  logic                w_frame_end_nxt;
  logic                w_accept;

  assign in_ready   = ~rst & ((r_state == IDLE) | (r_state == PARITY));
  assign busy       = (r_state == SHIFT) | (r_state == PARITY);
  assign w_accept   = in_valid & in_ready;

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_end  = r_frame_end;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next-cycle outputs. The output registers are loaded on the
  // same edge as the state, so the bit on dout always belongs to the current
  // state: SHIFT cycles carry data bits, the PARITY cycle carries parity.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_parity_nxt     = r_parity;
    w_dout_nxt       = 1'b0;
    w_dout_valid_nxt = 1'b0;
    w_frame_end_nxt  = 1'b0;
    case (r_state)
      IDLE, PARITY: begin
        if (w_accept) begin
          w_state_nxt      = SHIFT;
          w_shift_nxt      = {in_data[DATA_W-2:0], 1'b0};
          w_parity_nxt     = ^in_data;
          w_cnt_nxt        = '0;
          w_dout_nxt       = in_data[DATA_W-1];
          w_dout_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        w_dout_valid_nxt = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_state_nxt     = PARITY;
          w_cnt_nxt       = '0;
          w_dout_nxt      = r_parity;
          w_frame_end_nxt = 1'b1;
        end else begin
          w_dout_nxt  = r_shift[DATA_W-1];
          w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_parity     <= 1'b0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_frame_end  <= 1'b0;
    end else begin
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_parity     <= w_parity_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_frame_end  <= w_frame_end_nxt;
    end
  end

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Directed bench for parity_frame_serializer with an even-ones detector model.
module tb_parity_frame_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       dout;
  logic       dout_valid;
  logic       frame_end;
  logic       busy;

  int unsigned n_tests;
  int unsigned n_fail;

  logic det_odd;
  logic det_out;

  parity_frame_serializer #(.DATA_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_end  (frame_end),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream even-ones detector fed by the serial stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) det_odd <= 1'b0;
    else if (dout_valid && dout) det_odd <= ~det_odd;
  end
  assign det_out = ~det_odd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge where the first frame bit is visible; returns at the
  // negedge where the parity bit is visible. exp lists the 9 bits MSB first.
  // With jam set, in_valid is held high with changing in_data during the data
  // bits and dropped at the parity cycle.
  task automatic expect_frame(input string tag, input logic [8:0] exp, input bit jam);
    logic [7:0] junk;
    for (int i = 0; i < 9; i++) begin
      chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
      chk({tag, "_bit"}, 32'(dout), 32'(exp[8-i]));
      chk({tag, "_fend"}, 32'(frame_end), (i == 8) ? 32'd1 : 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (i < 8) chk({tag, "_rdy_shift"}, 32'(in_ready), 32'd0);
      else       chk({tag, "_rdy_par"}, 32'(in_ready), 32'd1);
      if (jam) begin
        junk     = 8'(i * 59 + 17);
        in_data  = junk;
        in_valid = (i < 8);
      end
      if (i < 8) @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_idle_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_idle_dout"}, 32'(dout), 32'd0);
    chk({tag, "_idle_fend"}, 32'(frame_end), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_det"}, 32'(det_out), 32'd1);
  endtask

  task automatic offer(input logic [7:0] w);
    in_data  = w;
    in_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_fend", 32'(frame_end), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_rdy", 32'(in_ready), 32'd1);

    // 8'hA5 -> 1,0,1,0,0,1,0,1 then parity 0.
    @(negedge clk);
    offer(8'hA5);
    @(negedge clk);
    in_valid = 1'b0;
    expect_frame("a5", 9'b1010_0101_0, 1'b0);
    @(negedge clk);
    check_idle("a5");

    // 8'h07 -> 0,0,0,0,0,1,1,1 then parity 1; detector reads 1 afterwards.
    offer(8'h07);
    @(negedge clk);
    in_valid = 1'b0;
    expect_frame("h07", 9'b0000_0111_1, 1'b0);
    @(negedge clk);
    check_idle("h07");

    // 8'hFF then 8'h01 back to back: 18 contiguous valid cycles.
    offer(8'hFF);
    @(negedge clk);
    in_data = 8'h01;
    expect_frame("ff", 9'b1111_1111_0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    expect_frame("b2b01", 9'b0000_0001_1, 1'b0);
    @(negedge clk);
    check_idle("b2b");

    // Changing in_data with in_valid held during SHIFT leaves the frame intact.
    offer(8'hA5);
    @(negedge clk);
    expect_frame("jam", 9'b1010_0101_0, 1'b1);
    @(negedge clk);
    check_idle("jam");

    // Reset after the 3rd bit of 8'hC3, then send 8'h80.
    offer(8'hC3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("c3_b0", 32'(dout), 32'd1);
    @(negedge clk);
    chk("c3_b1", 32'(dout), 32'd1);
    @(negedge clk);
    chk("c3_b2", 32'(dout), 32'd0);
    chk("c3_b2v", 32'(dout_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(dout_valid), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_fend", 32'(frame_end), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("inrst_valid", 32'(dout_valid), 32'd0);
    chk("inrst_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(in_ready), 32'd1);
    offer(8'h80);
    @(negedge clk);
    in_valid = 1'b0;
    expect_frame("h80", 9'b1000_0000_1, 1'b0);
    @(negedge clk);
    check_idle("h80");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
